// File: rtl/xif_mem_responder.sv
// XIF memory responder: turns coprocessor mem requests into OBI data accesses and
// returns in-order results one cycle after each OBI response.
module xif_mem_responder #(
  parameter int X_ID_WIDTH = 4,
  parameter int MAX_OUTST  = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  xif_mem_valid_i,
  output logic                  xif_mem_ready_o,
  input  logic [X_ID_WIDTH-1:0] xif_mem_id_i,
  input  logic [31:0]           xif_mem_addr_i,
  input  logic                  xif_mem_we_i,
  input  logic [1:0]            xif_mem_size_i,
  input  logic [31:0]           xif_mem_wdata_i,
  input  logic                  xif_mem_last_i,
  output logic                  xif_mem_resp_exc_o,
  output logic                  xif_mem_result_valid_o,
  output logic [X_ID_WIDTH-1:0] xif_mem_result_id_o,
  output logic [31:0]           xif_mem_result_rdata_o,
  output logic                  xif_mem_result_err_o,
  output logic                  xif_mem_last_done_o,
  output logic                  data_req_o,
  input  logic                  data_gnt_i,
  output logic [31:0]           data_addr_o,
  output logic                  data_we_o,
  output logic [3:0]            data_be_o,
  output logic [31:0]           data_wdata_o,
  input  logic                  data_rvalid_i,
  input  logic [31:0]           data_rdata_i,
  input  logic                  data_err_i,
  output logic                  busy_o,
  output logic                  proto_err_o
);

  localparam int PW = $clog2(MAX_OUTST);
  localparam int EW = X_ID_WIDTH + 6;

  logic [EW-1:0]         fifo_mem [MAX_OUTST];
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [PW:0]           count;
  logic [1:0]            off;
  logic                  illegal, full, empty, push, pop;
  logic [X_ID_WIDTH-1:0] head_id;
  logic [1:0]            head_off, head_size;
  logic                  head_we, head_last;
  logic [31:0]           rshift, load_data;

  assign off     = xif_mem_addr_i[1:0];
  assign illegal = (xif_mem_size_i == 2'd3) ||
                   (xif_mem_size_i == 2'd1 && off[0]) ||
                   (xif_mem_size_i == 2'd2 && off != 2'd0);
  assign full    = (count == (PW+1)'(MAX_OUTST));
  assign empty   = (count == '0);

  // Full is evaluated on the registered count, so a same-cycle pop never bypasses it.
  assign data_req_o         = xif_mem_valid_i & ~illegal & ~full;
  assign xif_mem_resp_exc_o = xif_mem_valid_i & illegal;
  assign xif_mem_ready_o    = xif_mem_resp_exc_o | (data_req_o & data_gnt_i);
  assign push               = data_req_o & data_gnt_i;
  assign pop                = data_rvalid_i & ~empty;

  assign data_addr_o  = {xif_mem_addr_i[31:2], 2'b00};
  assign data_we_o    = xif_mem_we_i;
  assign data_wdata_o = xif_mem_wdata_i << {off, 3'b000};

  always_comb begin
    data_be_o = 4'b1111;
    case (xif_mem_size_i)
      2'd0:    data_be_o = 4'b0001 << off;
      2'd1:    data_be_o = 4'b0011 << off;
      default: data_be_o = 4'b1111;
    endcase
  end

  assign {head_id, head_off, head_size, head_we, head_last} = fifo_mem[rd_ptr];

  assign rshift = data_rdata_i >> {head_off, 3'b000};
  always_comb begin
    load_data = rshift;
    case (head_size)
      2'd0:    load_data = {24'h0, rshift[7:0]};
      2'd1:    load_data = {16'h0, rshift[15:0]};
      default: load_data = rshift;
    endcase
  end

  // Storage is not reset; validity is carried entirely by the pointers and count.
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_mem[wr_ptr] <= {xif_mem_id_i, off, xif_mem_size_i, xif_mem_we_i, xif_mem_last_i};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      xif_mem_result_valid_o <= 1'b0;
      xif_mem_result_id_o    <= '0;
      xif_mem_result_rdata_o <= '0;
      xif_mem_result_err_o   <= 1'b0;
      xif_mem_last_done_o    <= 1'b0;
      proto_err_o            <= 1'b0;
    end else begin
      xif_mem_result_valid_o <= pop;
      xif_mem_result_id_o    <= pop ? head_id : '0;
      xif_mem_result_rdata_o <= (pop && !head_we) ? load_data : 32'h0;
      xif_mem_result_err_o   <= pop & data_err_i;
      xif_mem_last_done_o    <= pop & head_last;
      // A response arriving with nothing outstanding (including same cycle as the first grant).
      proto_err_o            <= proto_err_o | (data_rvalid_i & empty);
    end
  end

  assign busy_o = ~empty | xif_mem_result_valid_o;

endmodule

// File: tb/tb_xif_mem_responder.sv
// Bench for xif_mem_responder: directed scenarios plus random traffic against a queue model.
module tb_xif_mem_responder;

  localparam int MAXO = 4;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        xif_mem_valid, xif_mem_ready, xif_mem_we, xif_mem_last, xif_mem_resp_exc;
  logic [3:0]  xif_mem_id, xif_mem_result_id;
  logic [31:0] xif_mem_addr, xif_mem_wdata, xif_mem_result_rdata;
  logic [1:0]  xif_mem_size;
  logic        xif_mem_result_valid, xif_mem_result_err, xif_mem_last_done;
  logic        data_req, data_gnt, data_we, data_rvalid, data_err, busy, proto_err;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic [3:0]  data_be;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [3:0] id;
    int         off;
    int         size;
    logic       we;
    logic       last;
  } ent_t;

  ent_t        q[$];
  logic        exp_rv, exp_err, exp_last, exp_proto;
  logic [3:0]  exp_id;
  logic [31:0] exp_rdata;

  always #5 clk = ~clk;

  xif_mem_responder #(.X_ID_WIDTH(4), .MAX_OUTST(MAXO)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .xif_mem_valid_i(xif_mem_valid), .xif_mem_ready_o(xif_mem_ready),
    .xif_mem_id_i(xif_mem_id), .xif_mem_addr_i(xif_mem_addr),
    .xif_mem_we_i(xif_mem_we), .xif_mem_size_i(xif_mem_size),
    .xif_mem_wdata_i(xif_mem_wdata), .xif_mem_last_i(xif_mem_last),
    .xif_mem_resp_exc_o(xif_mem_resp_exc),
    .xif_mem_result_valid_o(xif_mem_result_valid), .xif_mem_result_id_o(xif_mem_result_id),
    .xif_mem_result_rdata_o(xif_mem_result_rdata), .xif_mem_result_err_o(xif_mem_result_err),
    .xif_mem_last_done_o(xif_mem_last_done),
    .data_req_o(data_req), .data_gnt_i(data_gnt), .data_addr_o(data_addr),
    .data_we_o(data_we), .data_be_o(data_be), .data_wdata_o(data_wdata),
    .data_rvalid_i(data_rvalid), .data_rdata_i(data_rdata), .data_err_i(data_err),
    .busy_o(busy), .proto_err_o(proto_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // A size is legal when it is byte/half/word and the address is naturally aligned to it.
  function automatic bit is_legal(input int size, input int off);
    return size < 3 && (off % (1 << size)) == 0;
  endfunction

  task automatic drive_idle();
    xif_mem_valid = 0; xif_mem_id = '0; xif_mem_addr = '0; xif_mem_we = 0;
    xif_mem_size = 2'd2; xif_mem_wdata = '0; xif_mem_last = 0;
    data_gnt = 0; data_rvalid = 0; data_rdata = '0; data_err = 0;
  endtask

  task automatic cycle(input logic v, input logic [3:0] id, input logic [31:0] addr,
                       input logic we, input logic [1:0] size, input logic [31:0] wd,
                       input logic last, input logic gnt, input logic rv,
                       input logic [31:0] rd, input logic err);
    int          off, sz, nb;
    logic        lg, e_req, e_exc;
    logic [3:0]  be_e;
    logic [31:0] wd_e, r;
    ent_t        e;
    @(negedge clk);
    xif_mem_valid = v; xif_mem_id = id; xif_mem_addr = addr; xif_mem_we = we;
    xif_mem_size = size; xif_mem_wdata = wd; xif_mem_last = last;
    data_gnt = gnt; data_rvalid = rv; data_rdata = rd; data_err = err;
    #1;
    off = int'(addr[1:0]);
    sz  = int'(size);
    lg  = is_legal(sz, off);
    e_exc = v && !lg;
    e_req = v && lg && (q.size() < MAXO);
    check("req", 32'(data_req), 32'(e_req));
    check("exc", 32'(xif_mem_resp_exc), 32'(e_exc));
    check("ready", 32'(xif_mem_ready), 32'(e_exc || (e_req && gnt)));
    if (e_req) begin
      nb = 1 << sz;
      be_e = '0;
      wd_e = '0;
      for (int i = 0; i < 4; i++) be_e[i] = (i >= off) && (i < off + nb);
      for (int k = 0; k < 4; k++) if (off + k < 4) wd_e[8*(off+k) +: 8] = wd[8*k +: 8];
      check("addr", data_addr, {addr[31:2], 2'b00});
      check("be", 32'(data_be), 32'(be_e));
      check("we", 32'(data_we), 32'(we));
      check("wdata", data_wdata, wd_e);
    end
    // Responses match only grants from earlier cycles, so pop before push.
    exp_rv = 0; exp_err = 0; exp_last = 0; exp_id = '0; exp_rdata = '0;
    if (rv) begin
      if (q.size() > 0) begin
        e = q.pop_front();
        r = '0;
        if (!e.we) for (int k = 0; k < (1 << e.size); k++) r[8*k +: 8] = rd[8*(e.off+k) +: 8];
        exp_rv = 1; exp_id = e.id; exp_err = err; exp_last = e.last; exp_rdata = r;
      end else begin
        exp_proto = 1;
      end
    end
    if (e_req && gnt) q.push_back('{id: id, off: off, size: sz, we: we, last: last});
    @(posedge clk);
    #1;
    check("res_valid", 32'(xif_mem_result_valid), 32'(exp_rv));
    check("last_done", 32'(xif_mem_last_done), 32'(exp_rv && exp_last));
    if (exp_rv) begin
      check("res_id", 32'(xif_mem_result_id), 32'(exp_id));
      check("res_rdata", xif_mem_result_rdata, exp_rdata);
      check("res_err", 32'(xif_mem_result_err), 32'(exp_err));
    end
    check("proto_err", 32'(proto_err), 32'(exp_proto));
    check("busy", 32'(busy), 32'(q.size() != 0 || exp_rv));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 2, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive_idle();
    rst_ni = 0;
    q.delete();
    exp_rv = 0;
    exp_proto = 0;
    #1;
    check("rst_valid", 32'(xif_mem_result_valid), 0);
    check("rst_last_done", 32'(xif_mem_last_done), 0);
    check("rst_proto", 32'(proto_err), 0);
    check("rst_busy", 32'(busy), 0);
    @(negedge clk);
    rst_ni = 1;
  endtask

  initial begin
    drive_idle();
    exp_proto = 0;
    exp_rv = 0;
    do_reset();
    idle(1);

    // Word load, response two cycles after grant.
    cycle(1, 3, 32'h100, 0, 2, 0, 0, 1, 0, 0, 0);
    idle(1);
    cycle(0, 0, 0, 0, 2, 0, 0, 0, 1, 32'hDEADBEEF, 0);
    idle(1);

    // Byte store to top lane, then half load from upper half, then misaligned word.
    cycle(1, 5, 32'h103, 1, 0, 32'hA5, 0, 1, 0, 0, 0);
    cycle(0, 0, 0, 0, 2, 0, 0, 0, 1, 32'hFFFFFFFF, 0);
    cycle(1, 6, 32'h102, 0, 1, 0, 0, 1, 0, 0, 0);
    cycle(0, 0, 0, 0, 2, 0, 0, 0, 1, 32'h12345678, 0);
    cycle(1, 7, 32'h101, 0, 2, 0, 0, 1, 0, 0, 0);
    cycle(1, 7, 32'h100, 0, 3, 0, 0, 1, 0, 0, 0);

    // Fill the FIFO, then show a same-cycle pop does not admit the fifth request.
    for (int i = 0; i < 4; i++) cycle(1, 4'(i), 32'h200 + 32'(4*i), 0, 2, 0, 0, 1, 0, 0, 0);
    cycle(1, 4, 32'h210, 0, 2, 0, 0, 1, 0, 0, 0);
    cycle(1, 4, 32'h210, 0, 2, 0, 0, 1, 1, 32'h11112222, 0);
    cycle(1, 4, 32'h210, 0, 2, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 2, 0, 0, 0, 1, 32'hA0 + 32'(i), 0);
    idle(1);

    // Erroring last access, then an unexpected response.
    cycle(1, 9, 32'h300, 0, 0, 0, 1, 1, 0, 0, 0);
    cycle(0, 0, 0, 0, 2, 0, 0, 0, 1, 32'h55, 1);
    cycle(0, 0, 0, 0, 2, 0, 0, 0, 1, 32'h66, 0);
    idle(2);

    // Reset with two outstanding accesses; a first grant with same-cycle rvalid is unexpected.
    cycle(1, 1, 32'h400, 0, 2, 0, 0, 1, 0, 0, 0);
    cycle(1, 2, 32'h404, 0, 2, 0, 0, 1, 0, 0, 0);
    do_reset();
    idle(3);
    cycle(1, 3, 32'h500, 0, 2, 0, 0, 1, 1, 32'h77, 0);
    cycle(0, 0, 0, 0, 2, 0, 0, 0, 1, 32'h88, 0);
    do_reset();

    for (int i = 0; i < 1500; i++) begin
      logic [1:0] sz;
      sz = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      cycle($urandom_range(0, 3) != 0, 4'($urandom), $urandom, 1'($urandom), sz, $urandom,
            1'($urandom), 1'($urandom), $urandom_range(0, 7) < (i < 750 ? 1 : 4),
            $urandom, 1'($urandom));
      if (i == 1000) do_reset();
    end
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
